i2c_slave_mem: RTL and testbench

I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

---
 rtl/i2c_slave_mem.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target with a 256x8 register memory, auto-incrementing pointer and write-event outputs.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda after the synchronizer.
module i2c_slave_mem #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1101001,
  parameter logic [7:0] MEM_INIT   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } StateT;

  logic [1:0] r_sclSync;
  logic [1:0] r_sdaSync;
  logic       w_scl;
  logic       w_sda;
  logic       r_sclPrev;
  logic       r_sdaPrev;
  logic       w_sclRise;
  logic       w_sclFall;
  logic       w_start;
  logic       w_stop;
  logic       w_byteDone;

  StateT      r_state;
  logic [3:0] r_bitCnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_sdaLow;
  logic       r_busy;
  logic       r_wrStrobe;
  logic [7:0] r_wrAddr;
  logic [7:0] r_wrData;
  logic       r_masterAck;
  logic [7:0] r_mem [0:255];

  // Idle bus is high, so the synchronizers come out of reset at 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclSync <= 2'b11;
      r_sdaSync <= 2'b11;
    end else begin
      r_sclSync <= {r_sclSync[0], scl};
      r_sdaSync <= {r_sdaSync[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] r_sclHist;
  logic [2:0] r_sdaHist;
  logic       r_sclFilt;
  logic       r_sdaFilt;

  // A level must be seen in two of the last three samples, so single-clk spikes never pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclHist <= 3'b111;
      r_sdaHist <= 3'b111;
      r_sclFilt <= 1'b1;
      r_sdaFilt <= 1'b1;
    end else begin
      r_sclHist <= {r_sclHist[1:0], r_sclSync[1]};
      r_sdaHist <= {r_sdaHist[1:0], r_sdaSync[1]};
      r_sclFilt <= (r_sclHist[0] & r_sclHist[1]) | (r_sclHist[0] & r_sclHist[2]) |
                   (r_sclHist[1] & r_sclHist[2]);
      r_sdaFilt <= (r_sdaHist[0] & r_sdaHist[1]) | (r_sdaHist[0] & r_sdaHist[2]) |
                   (r_sdaHist[1] & r_sdaHist[2]);
    end
  end

  assign w_scl = r_sclFilt;
  assign w_sda = r_sdaFilt;
`else
  assign w_scl = r_sclSync[1];
  assign w_sda = r_sdaSync[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclPrev <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
    end
  end

  assign w_sclRise  = w_scl & ~r_sclPrev;
  assign w_sclFall  = ~w_scl & r_sclPrev;
  assign w_start    = r_sclPrev & w_scl & r_sdaPrev & ~w_sda;
  assign w_stop     = r_sclPrev & w_scl & ~r_sdaPrev & w_sda;
  assign w_byteDone = w_sclFall && (r_bitCnt == 4'd8);

  // START/STOP take priority over everything, so a partial byte is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_ptr       <= 8'd0;
      r_sdaLow    <= 1'b0;
      r_busy      <= 1'b0;
      r_wrStrobe  <= 1'b0;
      r_wrAddr    <= 8'd0;
      r_wrData    <= 8'd0;
      r_masterAck <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        r_mem[i[7:0]] <= MEM_INIT;
      end
    end else begin
      r_wrStrobe <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sdaLow <= 1'b0;
        r_busy   <= 1'b0;
        r_bitCnt <= 4'd0;
      end else if (w_start) begin
        r_state  <= ADDR;
        r_sdaLow <= 1'b0;
        r_bitCnt <= 4'd0;
      end else begin
        if (w_sclRise && (r_state == ADDR || r_state == REG || r_state == WDATA)) begin
          r_shift  <= {r_shift[6:0], w_sda};
          r_bitCnt <= r_bitCnt + 4'd1;
        end
        case (r_state)
          ADDR: begin
            if (w_byteDone) begin
              r_bitCnt <= 4'd0;
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_state  <= ADDR_ACK;
                r_sdaLow <= 1'b1;
                r_busy   <= 1'b1;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          // The R/W bit is still in r_shift[0]; nothing shifts during ACK states.
          ADDR_ACK: begin
            if (w_sclFall) begin
              r_bitCnt <= 4'd0;
              if (r_shift[0]) begin
                r_state  <= RDATA;
                r_shift  <= r_mem[r_ptr];
                r_sdaLow <= ~r_mem[r_ptr][7];
              end else begin
                r_state  <= REG;
                r_sdaLow <= 1'b0;
              end
            end
          end
          REG: begin
            if (w_byteDone) begin
              r_bitCnt <= 4'd0;
              r_ptr    <= r_shift;
              r_sdaLow <= 1'b1;
              r_state  <= REG_ACK;
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (w_sclFall) begin
              r_sdaLow <= 1'b0;
              r_bitCnt <= 4'd0;
              r_state  <= WDATA;
            end
          end
          WDATA: begin
            if (w_byteDone) begin
              r_bitCnt      <= 4'd0;
              r_mem[r_ptr]  <= r_shift;
              r_wrStrobe    <= 1'b1;
              r_wrAddr      <= r_ptr;
              r_wrData      <= r_shift;
              r_ptr         <= r_ptr + 8'd1;
              r_sdaLow      <= 1'b1;
              r_state       <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (w_sclRise) begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end else if (w_sclFall) begin
              if (r_bitCnt == 4'd8) begin
                r_sdaLow <= 1'b0;
                r_ptr    <= r_ptr + 8'd1;
                r_bitCnt <= 4'd0;
                r_state  <= RDATA_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sdaLow <= ~r_shift[6];
              end
            end
          end
          RDATA_ACK: begin
            if (w_sclRise) begin
              r_masterAck <= ~w_sda;
            end else if (w_sclFall) begin
              r_bitCnt <= 4'd0;
              if (r_masterAck) begin
                r_state  <= RDATA;
                r_shift  <= r_mem[r_ptr];
                r_sdaLow <= ~r_mem[r_ptr][7];
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda       = r_sdaLow ? 1'b0 : 1'bz;
  assign busy      = r_busy;
  assign wr_strobe = r_wrStrobe;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Randomized bench for i2c_slave_mem: a bus-level master drives transactions while a
// byte-level memory/pointer model predicts ACKs, read data and write events.
module tb_i2c_slave_mem;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic mstLow = 1'b0;
  wire  sdaLine;
  logic busy;
  logic wrStrobe;
  logic [7:0] wrAddr;
  logic [7:0] wrData;

  pullup (sdaLine);
  assign sdaLine = mstLow ? 1'b0 : 1'bz;

  i2c_slave_mem dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sdaLine),
    .busy      (busy),
    .wr_strobe (wrStrobe),
    .wr_addr   (wrAddr),
    .wr_data   (wrData)
  );

  always #5 clk = ~clk;

  logic [7:0] modelMem [256];
  logic [7:0] modelPtr = 8'd0;
  logic [7:0] modelLastAddr = 8'd0;
  logic [7:0] modelLastData = 8'd0;
  logic [7:0] expAddrQ [$];
  logic [7:0] expDataQ [$];
  logic [7:0] dataBuf [8];
  logic [7:0] readBuf [8];
  int cmpCount = 0;
  int errCount = 0;
  bit silentWin = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write event must match the next byte the model queued; outside addressed
  // traffic the target must never pull sda or raise busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (wrStrobe) begin
        if (expAddrQ.size() == 0) begin
          cmpCount++;
          errCount++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write", wrAddr, wrData);
        end else begin
          checkOutput("strobe_addr", wrAddr, expAddrQ.pop_front());
          checkOutput("strobe_data", wrData, expDataQ.pop_front());
        end
      end
      if (silentWin && !mstLow) checkOutput("silent_sda", {7'd0, sdaLine}, 8'd1);
      if (silentWin) checkOutput("silent_busy", {7'd0, busy}, 8'd0);
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) modelMem[i] = 8'h00;
    modelPtr = 8'd0;
    modelLastAddr = 8'd0;
    modelLastData = 8'd0;
  endtask

  task automatic bitCell(input logic drvLow, output logic sampled);
    waitClk(4);
    mstLow = drvLow;
    waitClk(6);
    scl = 1'b1;
    waitClk(5);
    sampled = sdaLine;
    waitClk(5);
    scl = 1'b0;
  endtask

  task automatic startCond();
    mstLow = 1'b0;
    waitClk(10);
    scl = 1'b1;
    waitClk(HALF);
    mstLow = 1'b1;
    waitClk(HALF);
    scl = 1'b0;
  endtask

  task automatic stopCond();
    mstLow = 1'b1;
    waitClk(10);
    scl = 1'b1;
    waitClk(HALF);
    mstLow = 1'b0;
    waitClk(HALF);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bitCell(~b[i], s);
    bitCell(1'b0, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic ackIt, output logic [7:0] d);
    logic s;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bitCell(1'b0, s);
      d = {d[6:0], s};
    end
    bitCell(ackIt, s);
  endtask

  // kind 0: write ptrVal then n data bytes; kind 1: read n bytes (optionally setting ptr
  // first through a repeated START); kind 2: transaction to a foreign address.
  task automatic applyStimulus(input int kind, input logic [7:0] ptrVal, input int n,
                               input logic setPtr, input logic [7:0] foreign);
    logic ack;
    logic [7:0] d;
    if (kind == 2) begin
      silentWin = 1'b1;
      startCond();
      writeByte(foreign, ack);
      checkOutput("foreign_addr_nack", {7'd0, ack}, 8'd0);
      if (!foreign[0]) begin
        writeByte(ptrVal, ack);
        checkOutput("foreign_data_nack", {7'd0, ack}, 8'd0);
      end
      stopCond();
      waitClk(8);
      silentWin = 1'b0;
      return;
    end
    startCond();
    if (kind == 0 || setPtr) begin
      writeByte(8'hD2, ack);
      checkOutput("wr_addr_ack", {7'd0, ack}, 8'd1);
      checkOutput("busy_addressed", {7'd0, busy}, 8'd1);
      writeByte(ptrVal, ack);
      checkOutput("ptr_ack", {7'd0, ack}, 8'd1);
      modelPtr = ptrVal;
    end
    if (kind == 0) begin
      for (int k = 0; k < n; k++) begin
        expAddrQ.push_back(modelPtr);
        expDataQ.push_back(dataBuf[k]);
        modelMem[modelPtr] = dataBuf[k];
        modelLastAddr = modelPtr;
        modelLastData = dataBuf[k];
        modelPtr = modelPtr + 8'd1;
        writeByte(dataBuf[k], ack);
        checkOutput("data_ack", {7'd0, ack}, 8'd1);
      end
    end else begin
      if (setPtr) startCond();
      writeByte(8'hD3, ack);
      checkOutput("rd_addr_ack", {7'd0, ack}, 8'd1);
      for (int k = 0; k < n; k++) begin
        readByte(k != n - 1, d);
        readBuf[k] = d;
        checkOutput("read_data", d, modelMem[modelPtr]);
        modelPtr = modelPtr + 8'd1;
      end
      waitClk(8);
      checkOutput("sda_released_after_nack", {7'd0, sdaLine}, 8'd1);
    end
    stopCond();
    waitClk(8);
    checkOutput("busy_after_stop", {7'd0, busy}, 8'd0);
    checkOutput("wr_addr_hold", wrAddr, modelLastAddr);
    checkOutput("wr_data_hold", wrData, modelLastData);
  endtask

  initial begin
    #2_000_000;
    errCount++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

  initial begin
    logic ack;
    logic s;
    logic [6:0] fa;
    int kind;
    int n;
    modelReset();
    reset = 1'b1;
    waitClk(5);
    reset = 1'b0;
    waitClk(2);
    $display("[TB] reset state");
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_strobe", {7'd0, wrStrobe}, 8'd0);
    checkOutput("rst_wr_addr", wrAddr, 8'h00);
    checkOutput("rst_wr_data", wrData, 8'h00);
    checkOutput("rst_sda", {7'd0, sdaLine}, 8'd1);

    $display("[TB] directed write/read");
    dataBuf[0] = 8'h95;
    applyStimulus(0, 8'h8D, 1, 1'b1, 8'h00);
    checkOutput("lit_wr_addr", wrAddr, 8'h8D);
    checkOutput("lit_wr_data", wrData, 8'h95);
    applyStimulus(1, 8'h8D, 1, 1'b1, 8'h00);
    checkOutput("lit_read_95", readBuf[0], 8'h95);

    applyStimulus(2, 8'h11, 0, 1'b0, 8'hA0);
    applyStimulus(1, 8'h11, 1, 1'b1, 8'h00);
    checkOutput("lit_untouched_11", readBuf[0], 8'h00);

    $display("[TB] pointer wrap");
    dataBuf[0] = 8'h5A;
    applyStimulus(0, 8'h01, 1, 1'b1, 8'h00);
    dataBuf[0] = 8'h11;
    dataBuf[1] = 8'h22;
    applyStimulus(0, 8'hFF, 2, 1'b1, 8'h00);
    applyStimulus(1, 8'h00, 1, 1'b0, 8'h00);
    checkOutput("lit_ptr_after_wrap", readBuf[0], 8'h5A);
    applyStimulus(1, 8'hFF, 2, 1'b1, 8'h00);
    checkOutput("lit_wrap_ff", readBuf[0], 8'h11);
    checkOutput("lit_wrap_00", readBuf[1], 8'h22);

    $display("[TB] burst read");
    applyStimulus(1, 8'h8D, 2, 1'b1, 8'h00);
    checkOutput("lit_burst_0", readBuf[0], 8'h95);
    checkOutput("lit_burst_1", readBuf[1], 8'h00);

    $display("[TB] reset during address ACK");
    startCond();
    for (int i = 7; i >= 0; i--) bitCell(~(8'hD2 >> i) & 1'b1, s);
    mstLow = 1'b0;
    waitClk(8);
    checkOutput("ack_before_reset", {7'd0, sdaLine}, 8'd0);
    reset = 1'b1;
    waitClk(1);
    checkOutput("sda_released_on_reset", {7'd0, sdaLine}, 8'd1);
    reset = 1'b0;
    modelReset();
    waitClk(3);
    scl = 1'b1;
    waitClk(HALF);
    checkOutput("wr_addr_after_reset", wrAddr, 8'h00);
    dataBuf[0] = 8'hC3;
    applyStimulus(0, 8'h20, 1, 1'b1, 8'h00);
    applyStimulus(1, 8'h20, 1, 1'b1, 8'h00);
    checkOutput("lit_after_reset_write", readBuf[0], 8'hC3);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) dataBuf[k] = 8'($urandom);
      if (kind == 2) begin
        do fa = 7'($urandom); while (fa == 7'h69);
        applyStimulus(2, 8'($urandom), 0, 1'b0, {fa, 1'($urandom)});
      end else begin
        applyStimulus(kind, ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom), n,
                      1'($urandom), 8'h00);
      end
    end

    checkOutput("writes_outstanding", 8'(expAddrQ.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
